// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generator.
//   state_t : FSM state encoding (IDLE / SEND / GAP)
//   PAT_100 : default 3-bit pattern for the "100" detector chain
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [2:0] PAT_100 = 3'b100;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a zero flag.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (wins over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; holds at zero
//   count    : current count
//   zero     : high when count is zero
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sequence_generator_moore.sv
// Moore serial pattern generator. On an accepted start it sends a PAT_W-bit
// pattern MSB-first, one bit per clock, max(repeat_n,1) times, with
// GAP_CYCLES idle cycles between repetitions.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : transfer request, only honoured in IDLE
//   pattern  : pattern to send, captured on accepted start
//   repeat_n : repetition count, captured on accepted start (0 means 1)
//   x        : serial bit (IDLE_BIT when not sending)
//   x_valid  : x carries a pattern bit
//   busy     : transfer in progress (SEND or GAP)
//   done     : one-cycle pulse in the cycle after the final bit
module sequence_generator_moore
    import seq_gen_pkg::*;
#(
    parameter int   PAT_W      = 3,
    parameter int   CNT_W      = 4,
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W + 1);
    // Keep the gap counter at least one bit wide even when gaps are disabled.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    function automatic logic [CNT_W-1:0] clamp_reps(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(1) : n;
    endfunction

    state_t state, next_state;

    logic [PAT_W-1:0] shift_reg;
    logic [PAT_W-1:0] pat_hold;

    logic [BIT_W-1:0] bit_count;
    logic [GAP_W-1:0] gap_count;
    logic [CNT_W-1:0] rep_count;
    logic             bit_zero, gap_zero, rep_zero;

    logic bit_load, bit_dec;
    logic gap_load, gap_dec;
    logic rep_load, rep_dec;
    logic sh_load_new, sh_reload, sh_shift;
    logic done_next;

    logic bit_last, gap_last, reps_remain;

    // A zero count in SEND/GAP is treated as terminal so the FSM can never stall.
    assign bit_last    = (bit_count == BIT_W'(1)) || bit_zero;
    assign gap_last    = (gap_count == GAP_W'(1)) || gap_zero;
    // rep_count includes the repetition currently being sent.
    assign reps_remain = !rep_zero && (rep_count != CNT_W'(1));

    seq_down_counter #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (bit_load),
        .load_val (BIT_W'(PAT_W)),
        .dec      (bit_dec),
        .count    (bit_count),
        .zero     (bit_zero)
    );

    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_W'(GAP_CYCLES)),
        .dec      (gap_dec),
        .count    (gap_count),
        .zero     (gap_zero)
    );

    seq_down_counter #(.W(CNT_W)) u_rep_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rep_load),
        .load_val (clamp_reps(repeat_n)),
        .dec      (rep_dec),
        .count    (rep_count),
        .zero     (rep_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        bit_load    = 1'b0;
        bit_dec     = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        rep_load    = 1'b0;
        rep_dec     = 1'b0;
        sh_load_new = 1'b0;
        sh_reload   = 1'b0;
        sh_shift    = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state  = SEND;
                    bit_load    = 1'b1;
                    rep_load    = 1'b1;
                    sh_load_new = 1'b1;
                end
            end
            SEND: begin
                sh_shift = 1'b1;
                bit_dec  = 1'b1;
                if (bit_last) begin
                    if (reps_remain) begin
                        rep_dec = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            next_state = GAP;
                            gap_load   = 1'b1;
                        end else begin
                            // Back-to-back repetition: reload without leaving SEND.
                            bit_load  = 1'b1;
                            sh_reload = 1'b1;
                        end
                    end else begin
                        next_state = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_dec = 1'b1;
                if (gap_last) begin
                    next_state = SEND;
                    bit_load   = 1'b1;
                    sh_reload  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            pat_hold  <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_next;
            if (sh_load_new) begin
                shift_reg <= pattern;
                pat_hold  <= pattern;
            end else if (sh_reload) begin
                shift_reg <= pat_hold;
            end else if (sh_shift) begin
                shift_reg <= shift_reg << 1;
            end
        end
    end

    assign x       = (state == SEND) ? shift_reg[PAT_W-1] : IDLE_BIT;
    assign x_valid = (state == SEND);
    assign busy    = (state == SEND) || (state == GAP);

endmodule

// File: doc/sequence_generator_moore.md
# sequence_generator_moore

Moore-style serial pattern generator: on a start request it shifts a PAT_W-bit pattern out MSB-first, one bit per clock, repeated a programmable number of times with optional idle gaps. It is the transmit end of the team's serial-bit sequence path and drives the `x` input of the Moore sequence detectors in test and stimulus chains. All outputs are registered or decoded from state only, so none depends combinationally on inputs.

## Interface
- PAT_W, 3, pattern width in bits (≥1)
- CNT_W, 4, width of repetition count
- GAP_CYCLES, 1, idle cycles between repetitions (0 = back-to-back)
- IDLE_BIT, 1'b0, level driven on `x` when not sending
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- pattern  input  PAT_W  pattern to send; captured on accepted start
- repeat_n  input  CNT_W  repetition count; captured on accepted start; 0 treated as 1
- x  output  1  serial bit
- x_valid  output  1  high while `x` carries a pattern bit
- busy  output  1  high in SEND or GAP
- done  output  1  one-cycle pulse after final bit

One clock. Reset is synchronous and active-high.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: `start`=1 → SEND. Load the shift register with `pattern`, the bit counter with PAT_W, and the repetition counter with max(repeat_n, 1).
- SEND: `x` = shift_reg[PAT_W-1], x_valid=1. Shift left each cycle and decrement the bit counter. On the last bit:
  - if repetitions remain and GAP_CYCLES>0, go to GAP;
  - if repetitions remain and GAP_CYCLES=0, stay in SEND and reload the captured pattern;
  - otherwise go to IDLE and set `done`.
- GAP: `x`=IDLE_BIT, x_valid=0, busy=1 for exactly GAP_CYCLES cycles, then SEND with the captured pattern reloaded.
- Captured pattern and count are held internally. Changes on `pattern` or `repeat_n` while busy are ignored.
- `start` while busy is ignored (not queued).
- `start` during the `done` cycle is accepted, because the state is already IDLE.
- Outputs in IDLE: `x`=IDLE_BIT, x_valid=0, busy=0.
- `done` is registered: high for exactly one cycle after SEND→IDLE, otherwise 0.
- Reset at any time: next state IDLE, shift register and counters cleared, `x`=IDLE_BIT, x_valid=0, busy=0, done=0. No `done` is emitted for an aborted transfer.

## Timing
- Accepted `start` at edge k: first bit (pattern[PAT_W-1]) is on `x` during cycle k+1.
- Bit i (0 = MSB) appears in cycle k+1+i.
- Busy duration: R·PAT_W + (R−1)·GAP_CYCLES cycles, where R = max(repeat_n, 1).
- `done` is high in the first cycle after busy falls. busy=0 in that same cycle.
- Minimum start-to-start spacing: busy duration + 1 cycle.
- `rst` has priority over `start` in the same cycle.

## Structure
- Shared package `seq_gen_pkg`:
  - state typedef: IDLE=2'b00, SEND=2'b01, GAP=2'b10;
  - default pattern constant PAT_100 = 3'b100.
- Sub-module `seq_down_counter`: loadable down counter with a synchronous reset, a `zero` flag and a parameterised width. Instantiate it three times: bit counter, gap counter, repetition counter.
- Next-state logic is a single combinational case on state with `default` → IDLE. Outputs are decoded from state and the shift register.

## Test plan
- Reset then idle: hold `rst` 2 cycles, release, no `start` → x=IDLE_BIT, x_valid=0, busy=0, done=0 on every cycle.
- Single send: pattern=3'b100, repeat_n=1, `start` at edge k → x=1,0,0 with x_valid=1 in cycles k+1..k+3; done=1 in cycle k+4 only.
- Repeat with gap: pattern=3'b101, repeat_n=2, GAP_CYCLES=1 → x=1,0,1,gap,1,0,1; x_valid low in cycle k+4 only; done in cycle k+8. Loop into a detector for "101" → two detections.
- Zero count and ignored start: repeat_n=0 → exactly one repetition. A second `start` pulsed mid-send and a `pattern` change to 3'b011 mid-send have no effect on the output.
- Reset mid-operation: `rst` during the second bit → IDLE outputs next cycle, no `done`. A fresh `start` after release sends a full pattern from the MSB.
- Back-to-back: `start` held high continuously with repeat_n=1, GAP_CYCLES=0 → transfers separated by exactly one idle (done) cycle; a `done` pulse for each transfer.
